// File: rtl/padc_pkg.sv
// Shared constants and types for the 1.5-bit pipelined ADC front-end model.
package padc_pkg;

  localparam int unsigned NSTAGE = 7;

  typedef logic [1:0] code_t;

  localparam code_t CODE_P = 2'b01;
  localparam code_t CODE_Z = 2'b00;
  localparam code_t CODE_N = 2'b11;

  // Nominal comparator threshold FS/4 for an input width of w bits.
  function automatic int unsigned fs_quarter(input int unsigned w);
    return (32'(1) << (w - 1)) >> 2;
  endfunction

endpackage

// File: rtl/padc_stage.sv
// One registered 1.5-bit pipeline stage: decide, form residue 2v - d*FS, clip.
module padc_stage
  import padc_pkg::*;
#(
  parameter int unsigned W  = 10,
  parameter int unsigned IW = W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic signed [IW-1:0] res_in,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  ofs,
  output code_t                code,
  output logic                 code_valid,
  output logic signed [W:0]    res_out,
  output logic                 clip_c
);

  localparam int unsigned XW = W + 2;
  localparam logic signed [XW-1:0] FS_X  = XW'(32'(1) << (W - 1));
  localparam logic signed [XW-1:0] THR_X = XW'(fs_quarter(W));

  logic signed [XW-1:0] v_x;
  logic signed [XW-1:0] ofs_x;
  logic signed [XW-1:0] res_x;
  logic signed [XW-1:0] res_clip;
  code_t                code_d;

  // Decision against offset-shifted thresholds, residue and saturation.
  always_comb begin
    v_x      = XW'(res_in);
    ofs_x    = XW'(ofs);
    code_d   = CODE_Z;
    res_x    = v_x <<< 1;
    res_clip = '0;
    clip_c   = 1'b0;
    if (v_x > THR_X + ofs_x) begin
      code_d = CODE_P;
      res_x  = (v_x <<< 1) - FS_X;
    end else if (v_x < ofs_x - THR_X) begin
      code_d = CODE_N;
      res_x  = (v_x <<< 1) + FS_X;
    end
    res_clip = res_x;
    if (res_x > FS_X) begin
      res_clip = FS_X;
      clip_c   = in_valid;
    end else if (res_x < -FS_X) begin
      res_clip = -FS_X;
      clip_c   = in_valid;
    end
  end

  // Stage register; bubbles load a zero code and zero residue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code       <= CODE_Z;
      code_valid <= 1'b0;
      res_out    <= '0;
    end else if (in_valid) begin
      code       <= code_d;
      code_valid <= 1'b1;
      res_out    <= (W + 1)'(res_clip);
    end else begin
      code       <= CODE_Z;
      code_valid <= 1'b0;
      res_out    <= '0;
    end
  end

endmodule

// File: rtl/padc_stage_enc.sv
// Seven-stage 1.5-bit ADC front end with skewed codes, reference delay and clip flag.
module padc_stage_enc
  import padc_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic signed [W-1:0]      ain,
  input  logic                     ain_valid,
  input  logic signed [W-1:0]      ofs [NSTAGE],
  input  logic                     clr_err,
  output code_t                    dig_raw [NSTAGE],
  output logic [NSTAGE-1:0]        dig_raw_valid,
  output logic signed [W-1:0]      ref_ain,
  output logic                     ref_valid,
  output logic                     clip_err
);

  localparam int unsigned REF_DEPTH = NSTAGE + 1;

  logic signed [W:0]   res [NSTAGE];
  logic [NSTAGE-1:0]   clip_v;
  logic signed [W-1:0] ref_sh [REF_DEPTH];
  logic [REF_DEPTH-1:0] vld_sh;

  // Stage chain: stage 0 sees ain, stage i sees the residue of stage i-1.
  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      padc_stage #(.W(W), .IW(W)) u_stage (
        .clk        (clk),
        .rstn       (rstn),
        .res_in     (ain),
        .in_valid   (ain_valid),
        .ofs        (ofs[gi]),
        .code       (dig_raw[gi]),
        .code_valid (dig_raw_valid[gi]),
        .res_out    (res[gi]),
        .clip_c     (clip_v[gi])
      );
    end else begin : g_rest
      padc_stage #(.W(W), .IW(W + 1)) u_stage (
        .clk        (clk),
        .rstn       (rstn),
        .res_in     (res[gi-1]),
        .in_valid   (dig_raw_valid[gi-1]),
        .ofs        (ofs[gi]),
        .code       (dig_raw[gi]),
        .code_valid (dig_raw_valid[gi]),
        .res_out    (res[gi]),
        .clip_c     (clip_v[gi])
      );
    end
  end

  // Latency-matched copy of the input for scoreboarding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REF_DEPTH; i++) ref_sh[i] <= '0;
      vld_sh <= '0;
    end else begin
      ref_sh[0] <= ain;
      for (int i = 1; i < REF_DEPTH; i++) ref_sh[i] <= ref_sh[i-1];
      vld_sh <= {vld_sh[REF_DEPTH-2:0], ain_valid};
    end
  end

  assign ref_ain   = ref_sh[REF_DEPTH-1];
  assign ref_valid = vld_sh[REF_DEPTH-1];

  // Sticky saturation flag; a new clip wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clip_err <= 1'b0;
    end else if (|clip_v) begin
      clip_err <= 1'b1;
    end else if (clr_err) begin
      clip_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_padc_stage_enc.sv
// Directed self-checking bench for padc_stage_enc (W = 10, FS = 512).
module tb_padc_stage_enc;
  import padc_pkg::*;

  localparam int unsigned W = 10;

  logic                clk = 1'b0;
  logic                rstn;
  logic signed [W-1:0] ain;
  logic                ain_valid;
  logic signed [W-1:0] ofs [NSTAGE];
  logic                clr_err;
  code_t               dig_raw [NSTAGE];
  logic [NSTAGE-1:0]   dig_raw_valid;
  logic signed [W-1:0] ref_ain;
  logic                ref_valid;
  logic                clip_err;

  int n_chk  = 0;
  int n_fail = 0;

  padc_stage_enc #(.W(W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ain           (ain),
    .ain_valid     (ain_valid),
    .ofs           (ofs),
    .clr_err       (clr_err),
    .dig_raw       (dig_raw),
    .dig_raw_valid (dig_raw_valid),
    .ref_ain       (ref_ain),
    .ref_valid     (ref_valid),
    .clip_err      (clip_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NSTAGE; i++) begin
      chk($sformatf("%s_code%0d", tag, i), int'(dig_raw[i]), 0);
      chk($sformatf("%s_vld%0d", tag, i), int'(dig_raw_valid[i]), 0);
    end
    chk({tag, "_ref_ain"}, int'(ref_ain), 0);
    chk({tag, "_ref_valid"}, int'(ref_valid), 0);
    chk({tag, "_clip_err"}, int'(clip_err), 0);
  endtask

  // Single sample followed by bubbles; codes listed stage 0 first (MSB pair).
  task automatic run_sample(input string tag, input int a, input logic [13:0] exp_codes,
                            input int exp_d);
    int    dsum;
    code_t c;
    dsum      = 0;
    ain       = W'(a);
    ain_valid = 1'b1;
    for (int i = 0; i < NSTAGE; i++) begin
      tick();
      ain_valid = 1'b0;
      ain       = W'($urandom);
      c = dig_raw[i];
      chk($sformatf("%s_code%0d", tag, i), int'(c), int'(exp_codes[13-2*i -: 2]));
      chk($sformatf("%s_vld%0d", tag, i), int'(dig_raw_valid[i]), 1);
      if (c == CODE_P) dsum += (1 << (6 - i));
      else if (c == CODE_N) dsum -= (1 << (6 - i));
    end
    chk({tag, "_D"}, dsum, exp_d);
    tick();
    chk({tag, "_ref_valid"}, int'(ref_valid), 1);
    chk({tag, "_ref_ain"}, int'(ref_ain), a);
  endtask

  initial begin
    logic [6:0] pat;
    int         si;
    rstn      = 1'b0;
    ain       = '0;
    ain_valid = 1'b0;
    clr_err   = 1'b0;
    for (int i = 0; i < NSTAGE; i++) ofs[i] = '0;

    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      ain       = W'($urandom);
      ain_valid = 1'($urandom);
      clr_err   = 1'($urandom);
      tick();
    end
    chk_all_zero("rst_hold");
    ain_valid = 1'b0;
    clr_err   = 1'b0;
    rstn      = 1'b1;
    tick();

    // Stream samples, then reset mid-stream.
    ain_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ain = W'($urandom_range(0, 255));
      tick();
    end
    chk("pre_rst_ref_valid", int'(ref_valid), 1);
    chk("pre_rst_vld6", int'(dig_raw_valid[6]), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    ain_valid = 1'b0;
    rstn      = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("post_rst_ref_valid_c%0d", k), int'(ref_valid), 0);
      chk($sformatf("post_rst_vld_c%0d", k), int'(dig_raw_valid), 0);
    end

    // Basic conversions with zero offsets.
    run_sample("a0",    0,    14'b00_00_00_00_00_00_00, 0);
    run_sample("a256",  256,  14'b01_00_00_00_00_00_00, 64);
    run_sample("am512", -512, 14'b11_11_11_11_11_11_11, -127);
    run_sample("a511",  511,  14'b01_01_01_01_01_01_01, 127);
    chk("noclip_clip_err", int'(clip_err), 0);
    run_sample("a200",  200,  14'b01_00_11_00_00_01_00, 50);
    ofs[0] = W'(100);
    run_sample("a200o100", 200, 14'b00_01_01_00_00_01_00, 50);
    chk("ofs100_clip_err", int'(clip_err), 0);

    // Offset past the redundancy range forces a clip.
    ofs[0] = W'(300);
    run_sample("a400o300", 400, 14'b00_01_01_01_01_01_01, 63);
    chk("clip_set", int'(clip_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clip_cleared", int'(clip_err), 0);

    // Clip and clear in the same cycle: set wins.
    ain       = W'(400);
    ain_valid = 1'b1;
    clr_err   = 1'b1;
    tick();
    ain_valid = 1'b0;
    clr_err   = 1'b0;
    chk("clip_set_wins", int'(clip_err), 1);
    for (int k = 0; k < 8; k++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clip_cleared2", int'(clip_err), 0);
    ofs[0] = '0;

    // Bubble pattern 1,1,0,1,0,0,1 of full-scale negative samples.
    pat = 7'b1001011;
    for (int e = 0; e < 17; e++) begin
      if (e < 7) begin
        ain_valid = pat[e];
        ain       = pat[e] ? W'(-512) : W'($urandom);
      end else begin
        ain_valid = 1'b0;
        ain       = W'($urandom);
      end
      tick();
      for (int i = 0; i < NSTAGE; i++) begin
        si = e - i;
        if (si >= 0 && si < 7 && pat[si]) begin
          chk($sformatf("pat_e%0d_vld%0d", e, i), int'(dig_raw_valid[i]), 1);
          chk($sformatf("pat_e%0d_code%0d", e, i), int'(dig_raw[i]), int'(CODE_N));
        end else begin
          chk($sformatf("pat_e%0d_vld%0d", e, i), int'(dig_raw_valid[i]), 0);
          chk($sformatf("pat_e%0d_code%0d", e, i), int'(dig_raw[i]), int'(CODE_Z));
        end
      end
      si = e - 7;
      if (si >= 0 && si < 7 && pat[si]) begin
        chk($sformatf("pat_e%0d_ref_valid", e), int'(ref_valid), 1);
        chk($sformatf("pat_e%0d_ref_ain", e), int'(ref_ain), -512);
      end else begin
        chk($sformatf("pat_e%0d_ref_valid", e), int'(ref_valid), 0);
      end
    end
    chk("final_clip_err", int'(clip_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
